id_es_operand_stage: RTL and testbench
======================================

Name: id_es_operand_stage

Overview:
- Decode-to-execute pipeline register plus final ALU operand selection.
- Latches decoded fields and regfile read data from ID, with a writeback same-cycle bypass applied at capture.
- In EX, merges the registered forward flags/results from the forwarding unit into the final es_src1, es_src2 and store data.
- Obeys the shared stall[5:0]/flush pipeline control; counts bubble and hold cycles for performance debug.

Parameters:
- PC_WD, 32, pc width
- RESULT_WD, 32, operand/result width
- DEST_WD, 5, register index width
- CTRL_WD, 2, load/mul-div class tag consumed by hazard logic
- ALUOP_WD, 12, one-hot ALU op width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  pipeline flush
- stall  in  6  stall vector; bit2 = ID, bit3 = EX
- ds_valid  in  1  ID holds a valid instruction
- ds_pc  in  PC_WD  ID pc
- ds_alu_op  in  ALUOP_WD  decoded op
- ds_imm  in  RESULT_WD  extended immediate
- ds_src1_is_pc  in  1  src1 selects pc
- ds_src2_is_imm  in  1  src2 selects immediate
- ds_rj  in  DEST_WD  source 1 index
- ds_rkd  in  DEST_WD  source 2 index
- ds_dest  in  DEST_WD  destination
- ds_reg_we  in  1  writes register
- ds_ctrl  in  CTRL_WD  class tag
- rf_rdata1  in  RESULT_WD  regfile read, rj
- rf_rdata2  in  RESULT_WD  regfile read, rkd
- ws_reg_we  in  1  WB write enable
- ws_dest  in  DEST_WD  WB destination
- ws_result  in  RESULT_WD  WB data
- src1_is_forward  in  1  forwarding-unit flag, aligned to EX
- src2_is_forward  in  1  forwarding-unit flag, aligned to EX
- src1_forward_result  in  RESULT_WD  forwarded value
- src2_forward_result  in  RESULT_WD  forwarded value
- es_valid  out  1  EX valid
- es_pc  out  PC_WD  EX pc
- es_alu_op  out  ALUOP_WD  EX op
- es_dest  out  DEST_WD  EX destination
- es_reg_we  out  1  EX write enable, gated by es_valid
- es_ctrl  out  CTRL_WD  EX class tag, gated by es_valid
- es_src1  out  RESULT_WD  final ALU operand 1 (combinational from regs)
- es_src2  out  RESULT_WD  final ALU operand 2
- es_store_data  out  RESULT_WD  rkd value for stores
- bubble_cnt  out  32  bubbles inserted
- hold_cnt  out  32  cycles EX held

Behaviour:
- Edge priority, highest first:
  1. reset
  2. flush
  3. stall[2] & !stall[3] → bubble
  4. stall[2] & stall[3] → hold
  5. !stall[2] → load
- reset: all registers 0 (es_valid, es_pc, es_alu_op, es_dest, es_reg_we, es_ctrl, raw1, raw2, imm, select bits, both counters).
- flush: es_valid, es_reg_we, es_ctrl cleared; other fields don't-care. Counters unchanged.
- Bubble: es_valid=0, es_reg_we=0, es_ctrl=0; bubble_cnt+1. The forwarding unit clears its flags on the same condition, so operands of the bubble are don't-care.
- Hold: all registers keep their value; hold_cnt+1. Forward flags/results are held upstream on the same condition, so operands stay stable.
- Load: all ds_* captured; es_valid=ds_valid; es_reg_we=ds_reg_we&ds_valid; es_ctrl=ds_valid?ds_ctrl:0.
- WB bypass at capture: raw1 = (ws_reg_we & ws_dest==ds_rj & ds_rj!=0) ? ws_result : rf_rdata1. raw2 is the same form on ds_rkd.
- Operand mux (combinational in EX):
  - es_src1 = src1_is_pc ? es_pc (zero-extended) : src1_is_forward ? src1_forward_result : raw1
  - es_store_data = src2_is_forward ? src2_forward_result : raw2
  - es_src2 = src2_is_imm ? imm : es_store_data
- Index 0 is never bypassed: raw value is the regfile value (0).
- Counters wrap modulo 2^32.
- Latency: one cycle ID→EX. No combinational path from ds_* to es_* outputs.
- Reset asserted mid-hold: reset wins; counters cleared.

Test Plan:
- Reset, then ds_valid=1, pc=0x1c000000, rf_rdata1=5, rf_rdata2=7, no stall → next cycle es_valid=1, es_src1=5, es_src2=7.
- ws_reg_we=1, ws_dest=3, ws_result=0xAA, ds_rj=3, rf_rdata1=0x11 → es_src1=0xAA; repeat with ds_rj=0 → es_src1 = rf value 0.
- src1_is_forward=1, src1_forward_result=0x1234, raw1=0x1 → es_src1=0x1234. With ds_src2_is_imm=1, imm=0x10, src2 forwarded 0x99 → es_src2=0x10, es_store_data=0x99.
- stall=6'b000111 for 3 cycles → es_valid=0, es_reg_we=0, bubble_cnt=3; then stall=6'b001111 for 2 cycles → EX regs unchanged, hold_cnt=2.
- flush with stall[2]=0 and ds_valid=1 → es_valid=0, es_reg_we=0, es_ctrl=0 next cycle.
- Reset during hold with hold_cnt=4 → all outputs and both counters 0 next cycle.

Source files
------------

// File: rtl/id_es_operand_stage_if.sv
// ID-to-EX bus: decoded fields and regfile read data presented by the ID stage.
// The ID side drives it (master); the ID/EX register samples it (slave).
interface id_es_operand_stage_if #(
    parameter int PC_WD     = 32,
    parameter int RESULT_WD = 32,
    parameter int DEST_WD   = 5,
    parameter int CTRL_WD   = 2,
    parameter int ALUOP_WD  = 12
);
    logic                 ds_valid;
    logic [PC_WD-1:0]     ds_pc;
    logic [ALUOP_WD-1:0]  ds_alu_op;
    logic [RESULT_WD-1:0] ds_imm;
    logic                 ds_src1_is_pc;
    logic                 ds_src2_is_imm;
    logic [DEST_WD-1:0]   ds_rj;
    logic [DEST_WD-1:0]   ds_rkd;
    logic [DEST_WD-1:0]   ds_dest;
    logic                 ds_reg_we;
    logic [CTRL_WD-1:0]   ds_ctrl;
    logic [RESULT_WD-1:0] rf_rdata1;
    logic [RESULT_WD-1:0] rf_rdata2;

    modport master (
        output ds_valid, ds_pc, ds_alu_op, ds_imm,
        output ds_src1_is_pc, ds_src2_is_imm,
        output ds_rj, ds_rkd, ds_dest, ds_reg_we, ds_ctrl,
        output rf_rdata1, rf_rdata2
    );

    modport slave (
        input ds_valid, ds_pc, ds_alu_op, ds_imm,
        input ds_src1_is_pc, ds_src2_is_imm,
        input ds_rj, ds_rkd, ds_dest, ds_reg_we, ds_ctrl,
        input rf_rdata1, rf_rdata2
    );
endinterface

// File: rtl/id_es_operand_stage.sv
// ID/EX pipeline register with WB bypass at capture and EX operand selection.
// Also counts bubble and hold cycles for performance debug.
module id_es_operand_stage #(
    parameter int PC_WD     = 32,
    parameter int RESULT_WD = 32,
    parameter int DEST_WD   = 5,
    parameter int CTRL_WD   = 2,
    parameter int ALUOP_WD  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [5:0]           stall,
    id_es_operand_stage_if.slave id_bus,
    input  logic                 ws_reg_we,
    input  logic [DEST_WD-1:0]   ws_dest,
    input  logic [RESULT_WD-1:0] ws_result,
    input  logic                 src1_is_forward,
    input  logic                 src2_is_forward,
    input  logic [RESULT_WD-1:0] src1_forward_result,
    input  logic [RESULT_WD-1:0] src2_forward_result,
    output logic                 es_valid,
    output logic [PC_WD-1:0]     es_pc,
    output logic [ALUOP_WD-1:0]  es_alu_op,
    output logic [DEST_WD-1:0]   es_dest,
    output logic                 es_reg_we,
    output logic [CTRL_WD-1:0]   es_ctrl,
    output logic [RESULT_WD-1:0] es_src1,
    output logic [RESULT_WD-1:0] es_src2,
    output logic [RESULT_WD-1:0] es_store_data,
    output logic [31:0]          bubble_cnt,
    output logic [31:0]          hold_cnt
);
    logic [RESULT_WD-1:0] raw1;
    logic [RESULT_WD-1:0] raw2;
    logic [RESULT_WD-1:0] imm;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 bubble;
    logic                 hold;
    logic                 byp1;
    logic                 byp2;
    logic [RESULT_WD-1:0] cap1;
    logic [RESULT_WD-1:0] cap2;
    logic                 unused_stall;

    assign unused_stall = ^{stall[5:4], stall[1:0]};
    assign bubble       = stall[2] & ~stall[3];
    assign hold         = stall[2] & stall[3];

    // WB writes the regfile this same cycle; r0 is hardwired and never bypassed.
    assign byp1 = ws_reg_we && (ws_dest == id_bus.ds_rj)
                  && (id_bus.ds_rj != '0);
    assign byp2 = ws_reg_we && (ws_dest == id_bus.ds_rkd)
                  && (id_bus.ds_rkd != '0);
    assign cap1 = byp1 ? ws_result : id_bus.rf_rdata1;
    assign cap2 = byp2 ? ws_result : id_bus.rf_rdata2;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid    <= 1'b0;
            es_pc       <= '0;
            es_alu_op   <= '0;
            es_dest     <= '0;
            es_reg_we   <= 1'b0;
            es_ctrl     <= '0;
            raw1        <= '0;
            raw2        <= '0;
            imm         <= '0;
            src1_is_pc  <= 1'b0;
            src2_is_imm <= 1'b0;
            bubble_cnt  <= '0;
            hold_cnt    <= '0;
        end else if (flush) begin
            es_valid  <= 1'b0;
            es_reg_we <= 1'b0;
            es_ctrl   <= '0;
        end else if (bubble) begin
            es_valid   <= 1'b0;
            es_reg_we  <= 1'b0;
            es_ctrl    <= '0;
            bubble_cnt <= bubble_cnt + 32'd1;
        end else if (hold) begin
            hold_cnt <= hold_cnt + 32'd1;
        end else begin
            es_valid    <= id_bus.ds_valid;
            es_pc       <= id_bus.ds_pc;
            es_alu_op   <= id_bus.ds_alu_op;
            es_dest     <= id_bus.ds_dest;
            es_reg_we   <= id_bus.ds_reg_we & id_bus.ds_valid;
            es_ctrl     <= id_bus.ds_valid ? id_bus.ds_ctrl : '0;
            raw1        <= cap1;
            raw2        <= cap2;
            imm         <= id_bus.ds_imm;
            src1_is_pc  <= id_bus.ds_src1_is_pc;
            src2_is_imm <= id_bus.ds_src2_is_imm;
        end
    end

    // Forwarded results arrive aligned to EX and override the captured values.
    always_comb begin
        es_src1 = raw1;
        if (src1_is_pc) begin
            es_src1 = RESULT_WD'(es_pc);
        end else if (src1_is_forward) begin
            es_src1 = src1_forward_result;
        end
        es_store_data = src2_is_forward ? src2_forward_result : raw2;
        es_src2       = src2_is_imm ? imm : es_store_data;
    end
endmodule

// File: tb/tb_id_es_operand_stage.sv
// Scoreboard bench for id_es_operand_stage: expected EX state is queued when
// ID stimulus is driven and compared after the capturing clock edge.
module tb_id_es_operand_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [5:0]  stall;
    logic        ws_reg_we;
    logic [4:0]  ws_dest;
    logic [31:0] ws_result;
    logic        src1_is_forward;
    logic        src2_is_forward;
    logic [31:0] src1_forward_result;
    logic [31:0] src2_forward_result;
    logic        es_valid;
    logic [31:0] es_pc;
    logic [11:0] es_alu_op;
    logic [4:0]  es_dest;
    logic        es_reg_we;
    logic [1:0]  es_ctrl;
    logic [31:0] es_src1;
    logic [31:0] es_src2;
    logic [31:0] es_store_data;
    logic [31:0] bubble_cnt;
    logic [31:0] hold_cnt;

    int ntests = 0;
    int nfail  = 0;

    id_es_operand_stage_if bus ();

    id_es_operand_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .stall               (stall),
        .id_bus              (bus),
        .ws_reg_we           (ws_reg_we),
        .ws_dest             (ws_dest),
        .ws_result           (ws_result),
        .src1_is_forward     (src1_is_forward),
        .src2_is_forward     (src2_is_forward),
        .src1_forward_result (src1_forward_result),
        .src2_forward_result (src2_forward_result),
        .es_valid            (es_valid),
        .es_pc               (es_pc),
        .es_alu_op           (es_alu_op),
        .es_dest             (es_dest),
        .es_reg_we           (es_reg_we),
        .es_ctrl             (es_ctrl),
        .es_src1             (es_src1),
        .es_src2             (es_src2),
        .es_store_data       (es_store_data),
        .bubble_cnt          (bubble_cnt),
        .hold_cnt            (hold_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [4:0]  dest;
        logic        reg_we;
        logic [1:0]  ctrl;
        logic [31:0] raw1;
        logic [31:0] raw2;
        logic [31:0] imm;
        logic        s1pc;
        logic        s2imm;
        logic [31:0] bcnt;
        logic [31:0] hcnt;
        logic        ops;
    } st_t;

    st_t m;
    st_t sb[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic st_t model_next(st_t c);
        st_t n = c;
        n.ops = 1'b0;
        if (reset) begin
            n = '{default: '0};
            n.ops = 1'b1;
        end else if (flush) begin
            n.valid = 1'b0; n.reg_we = 1'b0; n.ctrl = 2'd0;
        end else if (stall[2] && !stall[3]) begin
            n.valid = 1'b0; n.reg_we = 1'b0; n.ctrl = 2'd0;
            n.bcnt = c.bcnt + 32'd1;
        end else if (stall[2] && stall[3]) begin
            n.hcnt = c.hcnt + 32'd1;
        end else begin
            n.valid  = bus.ds_valid;
            n.pc     = bus.ds_pc;
            n.alu_op = bus.ds_alu_op;
            n.dest   = bus.ds_dest;
            n.reg_we = bus.ds_reg_we && bus.ds_valid;
            n.ctrl   = bus.ds_valid ? bus.ds_ctrl : 2'd0;
            n.raw1   = (ws_reg_we && ws_dest == bus.ds_rj && bus.ds_rj != 0)
                       ? ws_result : bus.rf_rdata1;
            n.raw2   = (ws_reg_we && ws_dest == bus.ds_rkd && bus.ds_rkd != 0)
                       ? ws_result : bus.rf_rdata2;
            n.imm    = bus.ds_imm;
            n.s1pc   = bus.ds_src1_is_pc;
            n.s2imm  = bus.ds_src2_is_imm;
        end
        if (n.valid) n.ops = 1'b1;
        return n;
    endfunction

    task automatic cyc();
        st_t e;
        logic [31:0] x1, xs, x2;
        m = model_next(m);
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("valid", 32'(es_valid), 32'(e.valid));
        check("reg_we", 32'(es_reg_we), 32'(e.reg_we));
        check("ctrl", 32'(es_ctrl), 32'(e.ctrl));
        check("bubble_cnt", bubble_cnt, e.bcnt);
        check("hold_cnt", hold_cnt, e.hcnt);
        if (e.valid) begin
            check("pc", es_pc, e.pc);
            check("alu_op", 32'(es_alu_op), 32'(e.alu_op));
            check("dest", 32'(es_dest), 32'(e.dest));
        end
        if (e.ops) begin
            x1 = e.s1pc ? e.pc
                 : src1_is_forward ? src1_forward_result : e.raw1;
            xs = src2_is_forward ? src2_forward_result : e.raw2;
            x2 = e.s2imm ? e.imm : xs;
            check("src1", es_src1, x1);
            check("src2", es_src2, x2);
            check("store_data", es_store_data, xs);
        end
    endtask

    task automatic ds_set(input logic v, input logic [31:0] pc,
                          input logic [4:0] rj, input logic [31:0] r1,
                          input logic [4:0] rkd, input logic [31:0] r2);
        bus.ds_valid  = v;
        bus.ds_pc     = pc;
        bus.ds_rj     = rj;
        bus.rf_rdata1 = r1;
        bus.ds_rkd    = rkd;
        bus.rf_rdata2 = r2;
    endtask

    initial begin
        m = '{default: '0};
        reset = 1'b1; flush = 1'b0; stall = 6'd0;
        ws_reg_we = 1'b0; ws_dest = 5'd0; ws_result = 32'd0;
        src1_is_forward = 1'b0; src2_is_forward = 1'b0;
        src1_forward_result = 32'd0; src2_forward_result = 32'd0;
        ds_set(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.ds_alu_op = 12'd0; bus.ds_imm = 32'd0;
        bus.ds_src1_is_pc = 1'b0; bus.ds_src2_is_imm = 1'b0;
        bus.ds_dest = 5'd0; bus.ds_reg_we = 1'b0; bus.ds_ctrl = 2'd0;
        cyc();
        cyc();
        check("rst_valid", 32'(es_valid), 32'd0);
        check("rst_src1", es_src1, 32'd0);

        reset = 1'b0;
        ds_set(1'b1, 32'h1c00_0000, 5'd1, 32'd5, 5'd2, 32'd7);
        bus.ds_alu_op = 12'h001; bus.ds_dest = 5'd4;
        bus.ds_reg_we = 1'b1; bus.ds_ctrl = 2'd2;
        cyc();
        check("tp1_valid", 32'(es_valid), 32'd1);
        check("tp1_src1", es_src1, 32'd5);
        check("tp1_src2", es_src2, 32'd7);

        ws_reg_we = 1'b1; ws_dest = 5'd3; ws_result = 32'hAA;
        ds_set(1'b1, 32'h1c00_0004, 5'd3, 32'h11, 5'd3, 32'h22);
        cyc();
        check("byp_src1", es_src1, 32'hAA);
        check("byp_src2", es_src2, 32'hAA);
        ws_dest = 5'd0;
        ds_set(1'b1, 32'h1c00_0008, 5'd0, 32'd0, 5'd0, 32'd0);
        cyc();
        check("byp_r0_src1", es_src1, 32'd0);
        check("byp_r0_src2", es_src2, 32'd0);
        ws_dest = 5'd5;
        ds_set(1'b1, 32'h1c00_000c, 5'd6, 32'h66, 5'd5, 32'h55);
        cyc();
        check("nobyp_src1", es_src1, 32'h66);
        check("byp_rkd", es_store_data, 32'hAA);

        ws_reg_we = 1'b0;
        ds_set(1'b1, 32'h1c00_0010, 5'd1, 32'h1, 5'd2, 32'h3);
        bus.ds_src2_is_imm = 1'b1; bus.ds_imm = 32'h10;
        src1_is_forward = 1'b1; src1_forward_result = 32'h1234;
        src2_is_forward = 1'b1; src2_forward_result = 32'h99;
        cyc();
        check("fwd_src1", es_src1, 32'h1234);
        check("fwd_src2_imm", es_src2, 32'h10);
        check("fwd_store", es_store_data, 32'h99);
        src1_is_forward = 1'b0; src2_is_forward = 1'b0;

        bus.ds_src2_is_imm = 1'b0; bus.ds_src1_is_pc = 1'b1;
        ds_set(1'b1, 32'h1c00_0040, 5'd1, 32'h1, 5'd2, 32'h3);
        cyc();
        check("pc_src1", es_src1, 32'h1c00_0040);
        bus.ds_src1_is_pc = 1'b0;

        bus.ds_ctrl = 2'd3;
        ds_set(1'b0, 32'h1c00_0044, 5'd1, 32'h1, 5'd2, 32'h3);
        cyc();
        check("inv_ctrl", 32'(es_ctrl), 32'd0);
        bus.ds_ctrl = 2'd1;
        ds_set(1'b1, 32'h1c00_0048, 5'd1, 32'h1, 5'd2, 32'h3);
        cyc();

        stall = 6'b000111;
        repeat (3) cyc();
        check("bub_cnt3", bubble_cnt, 32'd3);
        check("bub_we", 32'(es_reg_we), 32'd0);
        stall = 6'b001111;
        repeat (2) cyc();
        check("hold_cnt2", hold_cnt, 32'd2);

        stall = 6'd0;
        ds_set(1'b1, 32'h1c00_0050, 5'd1, 32'h77, 5'd2, 32'h88);
        cyc();
        stall = 6'b001111;
        ds_set(1'b1, 32'h1c00_0054, 5'd1, 32'h12, 5'd2, 32'h34);
        repeat (2) cyc();
        check("hold_cnt4", hold_cnt, 32'd4);
        check("hold_pc", es_pc, 32'h1c00_0050);
        check("hold_src1", es_src1, 32'h77);

        reset = 1'b1;
        cyc();
        check("rsthold_hcnt", hold_cnt, 32'd0);
        check("rsthold_bcnt", bubble_cnt, 32'd0);
        check("rsthold_pc", es_pc, 32'd0);
        check("rsthold_valid", 32'(es_valid), 32'd0);
        reset = 1'b0; stall = 6'd0;

        flush = 1'b1;
        ds_set(1'b1, 32'h1c00_0060, 5'd1, 32'h1, 5'd2, 32'h2);
        cyc();
        check("flush_valid", 32'(es_valid), 32'd0);
        check("flush_we", 32'(es_reg_we), 32'd0);
        check("flush_ctrl", 32'(es_ctrl), 32'd0);
        flush = 1'b0;

        for (int i = 0; i < 80; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = 6'($urandom);
            stall[2] = ($urandom_range(0, 2) == 0);
            ws_reg_we = 1'($urandom);
            ws_dest = 5'($urandom_range(0, 3));
            ws_result = $urandom;
            ds_set(1'($urandom), $urandom, 5'($urandom_range(0, 3)),
                   $urandom, 5'($urandom_range(0, 3)), $urandom);
            bus.ds_alu_op = 12'(1 << $urandom_range(0, 11));
            bus.ds_imm = $urandom;
            bus.ds_src1_is_pc = 1'($urandom);
            bus.ds_src2_is_imm = 1'($urandom);
            bus.ds_dest = 5'($urandom);
            bus.ds_reg_we = 1'($urandom);
            bus.ds_ctrl = 2'($urandom);
            src1_is_forward = 1'($urandom);
            src2_is_forward = 1'($urandom);
            src1_forward_result = $urandom;
            src2_forward_result = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
